// File: rtl/axi_lite_arbiter_if.sv
// Signal bundle between the AXI4-Lite arbiter and its surroundings: raw master
// VALIDs, the monitored shared-slave handshake, and the arbiter's controls.
interface axi_lite_arbiter_if;
   logic m0_awvalid, m0_wvalid, m0_arvalid;
   logic m1_awvalid, m1_wvalid, m1_arvalid;
   logic S_AXI_AWVALID_MUX_OUT, S_AXI_AWREADY_MUX_OUT;
   logic S_AXI_WVALID_MUX_OUT,  S_AXI_WREADY_MUX_OUT;
   logic S_AXI_BVALID_MUX_OUT,  S_AXI_BREADY_MUX_OUT;
   logic S_AXI_ARVALID_MUX_OUT, S_AXI_ARREADY_MUX_OUT;
   logic S_AXI_RVALID_MUX_OUT,  S_AXI_RREADY_MUX_OUT;
   logic select, m0_en, m1_en, busy, protocol_err;

   modport slave (
      input  m0_awvalid, m0_wvalid, m0_arvalid,
      input  m1_awvalid, m1_wvalid, m1_arvalid,
      input  S_AXI_AWVALID_MUX_OUT, S_AXI_AWREADY_MUX_OUT,
      input  S_AXI_WVALID_MUX_OUT,  S_AXI_WREADY_MUX_OUT,
      input  S_AXI_BVALID_MUX_OUT,  S_AXI_BREADY_MUX_OUT,
      input  S_AXI_ARVALID_MUX_OUT, S_AXI_ARREADY_MUX_OUT,
      input  S_AXI_RVALID_MUX_OUT,  S_AXI_RREADY_MUX_OUT,
      output select, m0_en, m1_en, busy, protocol_err
   );

   modport master (
      output m0_awvalid, m0_wvalid, m0_arvalid,
      output m1_awvalid, m1_wvalid, m1_arvalid,
      output S_AXI_AWVALID_MUX_OUT, S_AXI_AWREADY_MUX_OUT,
      output S_AXI_WVALID_MUX_OUT,  S_AXI_WREADY_MUX_OUT,
      output S_AXI_BVALID_MUX_OUT,  S_AXI_BREADY_MUX_OUT,
      output S_AXI_ARVALID_MUX_OUT, S_AXI_ARREADY_MUX_OUT,
      output S_AXI_RVALID_MUX_OUT,  S_AXI_RREADY_MUX_OUT,
      input  select, m0_en, m1_en, busy, protocol_err
   );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master arbiter for a shared AXI4-Lite slave: switches the mux select only
// once the shared bus has drained, with round-robin ties and a bounded hold.
module axi_lite_arbiter #(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 2
) (
   input logic               S_AXI_ACLK,
   input logic               S_AXI_ARESETN,
   axi_lite_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t           r_state, w_nxt_state;
   logic             r_select, r_last, r_m0_en, r_m1_en, r_busy, r_protocol_err;
   logic             w_nxt_select, w_nxt_last;
   logic [7:0]       r_hold_cnt, w_nxt_hold;
   logic [8:0]       w_hold_sum;
   logic [CNT_W-1:0] r_aw_out, r_w_out, r_ar_out;
   logic [CNT_W:0]   w_aw_step, w_w_step, w_ar_step;
   logic             w_req0, w_req1, w_own_req, w_oth_req, w_winner;
   logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic             w_shared_valid, w_cnt_zero;

   // MSB of the result flags an overflow/underflow; the count then holds.
   function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
      logic [CNT_W:0] res;
      res = {1'b0, cnt};
      if (inc && !dec) begin
         if (&cnt) res = {1'b1, cnt};
         else      res = {1'b0, cnt + CNT_W'(1)};
      end else if (dec && !inc) begin
         if (cnt == {CNT_W{1'b0}}) res = {1'b1, cnt};
         else                      res = {1'b0, cnt - CNT_W'(1)};
      end else begin
         res = {1'b0, cnt};
      end
      return res;
   endfunction

   assign w_req0    = bus.m0_awvalid | bus.m0_wvalid | bus.m0_arvalid;
   assign w_req1    = bus.m1_awvalid | bus.m1_wvalid | bus.m1_arvalid;
   assign w_own_req = r_select ? w_req1 : w_req0;
   assign w_oth_req = r_select ? w_req0 : w_req1;
   assign w_winner  = (w_req0 & w_req1) ? ~r_last : w_req1;

   assign w_aw_hs = bus.S_AXI_AWVALID_MUX_OUT & bus.S_AXI_AWREADY_MUX_OUT;
   assign w_w_hs  = bus.S_AXI_WVALID_MUX_OUT  & bus.S_AXI_WREADY_MUX_OUT;
   assign w_b_hs  = bus.S_AXI_BVALID_MUX_OUT  & bus.S_AXI_BREADY_MUX_OUT;
   assign w_ar_hs = bus.S_AXI_ARVALID_MUX_OUT & bus.S_AXI_ARREADY_MUX_OUT;
   assign w_r_hs  = bus.S_AXI_RVALID_MUX_OUT  & bus.S_AXI_RREADY_MUX_OUT;

   assign w_shared_valid = bus.S_AXI_AWVALID_MUX_OUT | bus.S_AXI_WVALID_MUX_OUT |
                           bus.S_AXI_ARVALID_MUX_OUT;
   assign w_cnt_zero = (r_aw_out == {CNT_W{1'b0}}) && (r_w_out == {CNT_W{1'b0}}) &&
                       (r_ar_out == {CNT_W{1'b0}});

   assign w_aw_step  = cnt_step(r_aw_out, w_aw_hs, w_b_hs);
   assign w_w_step   = cnt_step(r_w_out,  w_w_hs,  w_b_hs);
   assign w_ar_step  = cnt_step(r_ar_out, w_ar_hs, w_r_hs);
   assign w_hold_sum = {1'b0, r_hold_cnt} + {8'd0, w_b_hs} + {8'd0, w_r_hs};

   // Next-state, next-select and hold-count decisions.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_select = r_select;
      w_nxt_last   = r_last;
      w_nxt_hold   = r_hold_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_req0 | w_req1) begin
               w_nxt_state  = ST_GRANT;
               w_nxt_select = w_winner;
               w_nxt_last   = w_winner;
               w_nxt_hold   = 8'd0;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (w_hold_sum >= 9'(MAX_BURST)) w_nxt_hold = 8'(MAX_BURST);
            else                             w_nxt_hold = w_hold_sum[7:0];
            // Leave only in a cycle where no new address/data is being offered.
            if (w_oth_req && ((r_hold_cnt == 8'(MAX_BURST)) || !w_own_req) &&
                !w_shared_valid) begin
               w_nxt_state = ST_DRAIN;
            end else begin
               w_nxt_state = ST_GRANT;
            end
         end
         ST_DRAIN: begin
            if (w_cnt_zero) begin
               if (w_oth_req) begin
                  w_nxt_state  = ST_GRANT;
                  w_nxt_select = ~r_select;
                  w_nxt_last   = ~r_select;
                  w_nxt_hold   = 8'd0;
               end else begin
                  w_nxt_state = ST_IDLE;
               end
            end else begin
               w_nxt_state = ST_DRAIN;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   // State and registered controls; enables follow the state they enter.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state    <= ST_IDLE;
         r_select   <= 1'b0;
         r_last     <= 1'b1;
         r_m0_en    <= 1'b0;
         r_m1_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_hold_cnt <= 8'd0;
      end else begin
         r_state    <= w_nxt_state;
         r_select   <= w_nxt_select;
         r_last     <= w_nxt_last;
         r_m0_en    <= (w_nxt_state == ST_GRANT) && !w_nxt_select;
         r_m1_en    <= (w_nxt_state == ST_GRANT) && w_nxt_select;
         r_busy     <= (w_nxt_state != ST_IDLE);
         r_hold_cnt <= w_nxt_hold;
      end
   end

   // Outstanding-transaction counters and the sticky protocol error.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_aw_out       <= {CNT_W{1'b0}};
         r_w_out        <= {CNT_W{1'b0}};
         r_ar_out       <= {CNT_W{1'b0}};
         r_protocol_err <= 1'b0;
      end else begin
         r_aw_out       <= w_aw_step[CNT_W-1:0];
         r_w_out        <= w_w_step[CNT_W-1:0];
         r_ar_out       <= w_ar_step[CNT_W-1:0];
         r_protocol_err <= r_protocol_err | w_aw_step[CNT_W] | w_w_step[CNT_W] |
                           w_ar_step[CNT_W];
      end
   end

   assign bus.select       = r_select;
   assign bus.m0_en        = r_m0_en;
   assign bus.m1_en        = r_m1_en;
   assign bus.busy         = r_busy;
   assign bus.protocol_err = r_protocol_err;
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Transaction-safe arbiter that shares the equalizer's single AXI4-Lite tap/coefficient register slave between two masters: master 0 (processor AXI4-Lite bus) and master 1 (on-chip controller). It drives the select of the existing two-to-one AXI4-Lite bus mux and gates each master's VALIDs before the mux. It changes the select only when the shared bus is quiescent, never mid-transaction. It gives round-robin fairness with a bounded hold.

## Interface
- MAX_BURST, 4, transactions (B or R handshakes) an owner may complete before yielding to a waiting master; 1..255
- CNT_W, 2, width of outstanding-transaction counters
- S_AXI_ACLK  in  1  clock for everything
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- m0_awvalid, m0_wvalid, m0_arvalid  in  1 each  raw (ungated) VALIDs of master 0; request detection
- m1_awvalid, m1_wvalid, m1_arvalid  in  1 each  raw VALIDs of master 1
- S_AXI_AWVALID_MUX_OUT, S_AXI_AWREADY_MUX_OUT, S_AXI_WVALID_MUX_OUT, S_AXI_WREADY_MUX_OUT, S_AXI_BVALID_MUX_OUT, S_AXI_BREADY_MUX_OUT, S_AXI_ARVALID_MUX_OUT, S_AXI_ARREADY_MUX_OUT, S_AXI_RVALID_MUX_OUT, S_AXI_RREADY_MUX_OUT  in  1 each  monitored shared-slave handshake signals
- select  out  1  mux select; 0 = master 0, 1 = master 1
- m0_en, m1_en  out  1 each  VALID enables; integration ANDs mN AW/W/AR VALIDs with mN_en ahead of the mux
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky counter overflow/underflow flag

## Operation
- reqN = mN_awvalid | mN_wvalid | mN_arvalid.
- Counters, updated on shared-side handshakes (VALID & READY):
  - aw_out: +1 on AW, −1 on B.
  - w_out: +1 on W, −1 on B.
  - ar_out: +1 on AR, −1 on R.
  - Increment and decrement in the same cycle give a net change of 0.
  - Increment at all-ones, or decrement at 0: counter holds and protocol_err sets. protocol_err clears only on reset.
- quiet = all three counters 0 and shared AWVALID, WVALID, ARVALID all low.
- hold_cnt (8 bit):
  - Cleared on entry to GRANT.
  - In GRANT: + (B hs) + (R hs) per cycle, saturating at MAX_BURST.
- last: owner of the most recent grant. Reset value 1, so master 0 wins the first tie.
- States:
  - IDLE
    - Both enables 0.
    - Any req: choose winner and go to GRANT, setting select = winner and last = winner.
    - Winner rule: the sole requester; if both request, !last.
  - GRANT
    - en[select] = 1; the other enable is 0.
    - Go to DRAIN when the other master requests AND (hold_cnt == MAX_BURST OR owner req low) AND no shared AW/W/AR VALID this cycle.
    - No request from the other master: stay in GRANT (owner parks, select held).
  - DRAIN
    - Both enables 0; owner's new VALIDs are blocked.
    - When all counters are 0: if the other master still requests, go to GRANT with select = other and last = other; otherwise go to IDLE.
- select changes only on the DRAIN→GRANT or IDLE→GRANT edge, and only while both enables were 0 and no transaction was in flight.

## Timing
- Reset values: state IDLE, select 0, m0_en 0, m1_en 0, busy 0, protocol_err 0, all counters 0, hold_cnt 0, last 1.
- Enables and select are registered outputs and change together on the state-transition edge.
- IDLE→GRANT: request high at edge t → select and en valid after edge t (1-cycle grant latency).
- GRANT→DRAIN: en drops at the edge where the condition is sampled. A VALID the owner raises after that edge never reaches the slave, so no VALID is withdrawn.
- DRAIN exits at the first edge where the counters sample 0. Minimum handover, owner to other, is 2 edges.
- B and AW handshakes in the same cycle leave aw_out unchanged; B and R in the same cycle add 2 to hold_cnt.
- Reset asserted mid-transaction: all outputs take reset values immediately (asynchronous). In-flight transactions are abandoned; the slave shares the same reset.

## Test plan
- Reset then m0_arvalid high at edge 3 → select 0, m0_en 1 after edge 3. Single read with R handshake → ar_out 1→0. State stays GRANT.
- Both masters request from reset → master 0 granted first. Master 0 completes 4 writes with m1_arvalid held high → DRAIN after the 4th B, then select 1 and m1_en 1 two edges later.
- Owner raises m0_awvalid in the cycle after en drops → shared AWVALID stays 0. Master 0 is re-granted after master 1 finishes and master 1's req falls.
- Master 1 requests while master 0's AW is accepted but B is pending → select stays 0 until B handshake, then switches.
- B handshake with aw_out = 0 → protocol_err 1, aw_out stays 0. protocol_err stays 1 until reset.
- S_AXI_ARESETN low during DRAIN with w_out = 1 → select 0, enables 0, counters 0 immediately; IDLE after release.
